mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 153 +++++++++++++++
 tb/tb_mem_lsu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu : single-outstanding load/store unit in front of a word-addressed
//           memory. One request is accepted at a time; it is range-checked,
//           turned into a memory write or read, and answered with one response.
//
// Parameters
//   p_WORD_LEN    bits per data word and width of the request address
//   p_ADDR_LEN    memory address lines (memory depth 2**p_ADDR_LEN words)
//   p_RD_LATENCY  memory read latency: 0 = async read, 1 = registered read
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_req_valid / o_req_ready    request handshake (ready only when idle)
//   i_req_we, i_req_addr,        request: 1 = store / 0 = load, word address,
//   i_req_wdata                  store data
//   o_rsp_valid / i_rsp_ready    response handshake
//   o_rsp_rdata, o_rsp_err       load data (0 for stores/errors), range error
//   o_mem_wr_en, o_mem_addr,     memory port driven from captured request
//   o_mem_wr_data, i_mem_rd_data
// -----------------------------------------------------------------------------
module mem_lsu #(
    parameter int p_WORD_LEN   = 16,
    parameter int p_ADDR_LEN   = 10,
    parameter int p_RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [p_WORD_LEN-1:0] i_req_addr,
    input  logic [p_WORD_LEN-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [p_WORD_LEN-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_mem_wr_en,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_we;
    logic                  r_wr_en;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [p_WORD_LEN-1:0] r_rsp_rdata;
    logic [p_ADDR_LEN-1:0] r_mem_addr;
    logic [p_WORD_LEN-1:0] r_wdata;

    logic w_accept;
    logic w_out_of_range;

    assign w_accept = i_req_valid && r_req_ready;

    // Any address bit at or above p_ADDR_LEN set means the word is not backed
    // by memory. A shift keeps this legal even when both widths are equal.
    assign w_out_of_range = (i_req_addr >> p_ADDR_LEN) != '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                // Accept: capture the request; errors skip the memory access.
                S_IDLE: begin
                    if (w_accept) begin
                        r_mem_addr  <= i_req_addr[p_ADDR_LEN-1:0];
                        r_wdata     <= i_req_wdata;
                        r_we        <= i_req_we;
                        r_req_ready <= 1'b0;
                        if (w_out_of_range) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state <= S_ACCESS;
                            r_wr_en <= i_req_we;
                        end
                    end
                end
                // Access: the write pulse lives only in this cycle.
                S_ACCESS: begin
                    r_wr_en <= 1'b0;
                    if (r_we) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end else if (p_RD_LATENCY == 0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= i_mem_rd_data;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                // Wait: registered memory output is valid on this edge.
                S_WAIT: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= i_mem_rd_data;
                end
                // Response: hold until consumed, then reopen for requests.
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_wr_en     <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wr_data = r_wdata;
    // Reset landing on the access cycle must not corrupt memory.
    assign o_mem_wr_en   = r_wr_en && !i_rst;

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu : two mem_lsu instances (index 0 registered-read memory,
// index 1 async-read memory) exercised by one driver; a scoreboard queue per
// instance holds the expected response computed from a plain array model.
// -----------------------------------------------------------------------------
module tb_mem_lsu;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst         [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_we      [2];
    logic [15:0] req_addr    [2];
    logic [15:0] req_wdata   [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [15:0] rsp_rdata   [2];
    logic        rsp_err     [2];
    logic        mem_wr_en   [2];
    logic [9:0]  mem_addr    [2];
    logic [15:0] mem_wr_data [2];
    logic [15:0] mem_rd_data [2];

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;

    exp_t        sbq [2][$];
    logic [15:0] ref_mem [2][1024];
    logic [9:0]  exp_waddr [2];
    logic [15:0] exp_wdata [2];
    int          exp_stores [2];
    int          pulses [2];
    int          hold [2];
    int          hold_req [2];
    logic        pend [2];
    logic [15:0] obs_rd [2];
    logic        obs_err [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [1024] = '{default: '0};

        mem_lsu #(
            .p_WORD_LEN  (16),
            .p_ADDR_LEN  (10),
            .p_RD_LATENCY(g == 0 ? 1 : 0)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst[g]),
            .i_req_valid  (req_valid[g]),
            .o_req_ready  (req_ready[g]),
            .i_req_we     (req_we[g]),
            .i_req_addr   (req_addr[g]),
            .i_req_wdata  (req_wdata[g]),
            .o_rsp_valid  (rsp_valid[g]),
            .i_rsp_ready  (rsp_ready[g]),
            .o_rsp_rdata  (rsp_rdata[g]),
            .o_rsp_err    (rsp_err[g]),
            .o_mem_wr_en  (mem_wr_en[g]),
            .o_mem_addr   (mem_addr[g]),
            .o_mem_wr_data(mem_wr_data[g]),
            .i_mem_rd_data(mem_rd_data[g])
        );

        always @(posedge clk) if (mem_wr_en[g]) mem[mem_addr[g]] <= mem_wr_data[g];

        if (g == 0) begin : g_regrd
            logic [15:0] rd_q = '0;
            always @(posedge clk) rd_q <= mem[mem_addr[g]];
            assign mem_rd_data[g] = rd_q;
        end else begin : g_asyncrd
            assign mem_rd_data[g] = mem[mem_addr[g]];
        end
    end

    function automatic void chk(int k, string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endfunction

    // Reference model: a word array plus the response rules.
    function automatic void ref_issue(int k, bit we, logic [15:0] addr, logic [15:0] wd, int acc);
        exp_t e;
        bit   err;
        err     = addr >= 16'd1024;
        e.acc   = acc;
        e.err   = err;
        e.rdata = 16'h0;
        if (err)     e.lat = 1;
        else if (we) e.lat = 2;
        else         e.lat = (k == 0) ? 3 : 2;
        if (!err && we) begin
            ref_mem[k][addr[9:0]] = wd;
            exp_waddr[k] = addr[9:0];
            exp_wdata[k] = wd;
            exp_stores[k]++;
        end else if (!err) begin
            e.rdata = ref_mem[k][addr[9:0]];
        end
        sbq[k].push_back(e);
    endfunction

    // Present a request, wait (bounded) for acceptance; returns after accept edge.
    task automatic present(int k, bit we, logic [15:0] addr, logic [15:0] wd, output bit ok);
        int n;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        n = 0;
        while (!req_ready[k] && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready[k];
        chk(k, "accept_timeout", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
    endtask

    task automatic issue(int k, bit we, logic [15:0] addr, logic [15:0] wd);
        bit ok;
        present(k, we, addr, wd, ok);
        if (ok) ref_issue(k, we, addr, wd, cyc + 1);
        @(negedge clk);
        req_valid[k] = 1'b0;
    endtask

    task automatic check_idle(int k);
        chk(k, "rst_req_ready", 32'(req_ready[k]), 32'd1);
        chk(k, "rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        chk(k, "rst_rsp_err", 32'(rsp_err[k]), 32'd0);
        chk(k, "rst_rsp_rdata", 32'(rsp_rdata[k]), 32'd0);
        chk(k, "rst_mem_addr", 32'(mem_addr[k]), 32'd0);
        chk(k, "rst_mem_wr_data", 32'(mem_wr_data[k]), 32'd0);
        chk(k, "rst_mem_wr_en", 32'(mem_wr_en[k]), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each new response, checks stability
    // while the response is held, and drives rsp_ready with random back-pressure.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                pend[k]      = 1'b0;
                rsp_ready[k] = 1'b0;
            end else begin
                if (mem_wr_en[k]) begin
                    pulses[k]++;
                    chk(k, "wr_addr", 32'(mem_addr[k]), 32'(exp_waddr[k]));
                    chk(k, "wr_data", 32'(mem_wr_data[k]), 32'(exp_wdata[k]));
                end
                if (rsp_valid[k]) begin
                    if (!pend[k]) begin
                        pend[k]    = 1'b1;
                        obs_rd[k]  = rsp_rdata[k];
                        obs_err[k] = rsp_err[k];
                        if (sbq[k].size() == 0) begin
                            compared++;
                            failed++;
                            $display("FAIL unexpected_rsp[%0d]: got rdata 0x%0h err %0d, expected no response", k, rsp_rdata[k], rsp_err[k]);
                        end else begin
                            e = sbq[k].pop_front();
                            chk(k, "rsp_rdata", 32'(rsp_rdata[k]), 32'(e.rdata));
                            chk(k, "rsp_err", 32'(rsp_err[k]), 32'(e.err));
                            chk(k, "rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                        end
                        if (hold_req[k] > 0) hold[k] = hold_req[k];
                        else hold[k] = int'($urandom_range(0, 2));
                        hold_req[k] = 0;
                    end else begin
                        chk(k, "hold_rdata", 32'(rsp_rdata[k]), 32'(obs_rd[k]));
                        chk(k, "hold_err", 32'(rsp_err[k]), 32'(obs_err[k]));
                        chk(k, "hold_req_ready", 32'(req_ready[k]), 32'd0);
                    end
                    rsp_ready[k] = (hold[k] == 0);
                    if (hold[k] > 0) hold[k]--;
                end else begin
                    pend[k]      = 1'b0;
                    rsp_ready[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int r;
        logic [15:0] a;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
            exp_waddr[k] = '0; exp_wdata[k] = '0; exp_stores[k] = 0;
            pulses[k] = 0; hold[k] = 0; hold_req[k] = 0; pend[k] = 1'b0;
            obs_rd[k] = '0; obs_err[k] = 1'b0;
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        check_idle(0);
        check_idle(1);

        for (int k = 0; k < 2; k++) begin
            issue(k, 1'b1, 16'h0005, 16'h1234);
            issue(k, 1'b0, 16'h0005, 16'h0000);
            issue(k, 1'b0, 16'h0400, 16'h0000);
            issue(k, 1'b1, 16'h0400, 16'hDEAD);
            issue(k, 1'b1, 16'h03FF, 16'hBEEF);
            issue(k, 1'b0, 16'h03FF, 16'h0000);
            hold_req[k] = 5;
            issue(k, 1'b0, 16'h0005, 16'h0000);

            // Store aborted by reset during its access cycle.
            issue(k, 1'b1, 16'h0010, 16'h5555);
            present(k, 1'b1, 16'h0010, 16'hAAAA, ok);
            #1 rst[k] = 1'b1;
            @(negedge clk);
            chk(k, "abort_wr_en", 32'(mem_wr_en[k]), 32'd0);
            req_valid[k] = 1'b0;
            @(posedge clk);
            #1 rst[k] = 1'b0;
            @(negedge clk);
            check_idle(k);
            issue(k, 1'b0, 16'h0010, 16'h0000);

            for (int i = 0; i < 120; i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 7)       a = 16'($urandom_range(0, 15));
                else if (r == 7) a = 16'h03FF;
                else if (r == 8) a = 16'h0400;
                else             a = 16'($urandom);
                issue(k, 1'($urandom_range(0, 1)), a, 16'($urandom));
            end
        end

        n = 0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0 || rsp_valid[0] || rsp_valid[1]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 2; k++) begin
            chk(k, "drain_queue", 32'(sbq[k].size()), 32'd0);
            chk(k, "wr_pulses", 32'(pulses[k]), 32'(exp_stores[k]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
